adc_stream_rx: RTL

AXI-Stream sink for the ADC capture stream: accepts the 32-bit tagged sample words produced by the triggered ADC block, checks burst framing, unpacks each word into two signed 16-bit channel samples, and buffers them in a small FIFO for a downstream consumer with backpressure. It sits between the ADC capture core and any on-chip consumer that cannot take the raw DMA path, such as a live monitor, a DAC loopback or a test harness. It also keeps burst and error statistics for software.

---
 rtl/adc_stream_rx_pkg.sv | 37 +++
 rtl/adc_stream_rx_sync_fifo_fwft.sv | 54 +++++
 rtl/adc_stream_rx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/adc_stream_rx_pkg.sv
// adc_stream_rx_pkg
// Shared definitions for the ADC stream receiver: tagged word field
// positions, sample widths, FIFO entry layout, receiver state encoding and
// small arithmetic helpers.
package adc_stream_rx_pkg;

   // Tagged word layout: [31] marker, [30] last flag, [29:15] A, [14:0] B
   localparam int unsigned MARKER_BIT = 31;
   localparam int unsigned LAST_BIT   = 30;
   localparam int unsigned A_MSB      = 29;
   localparam int unsigned A_LSB      = 15;
   localparam int unsigned B_MSB      = 14;
   localparam int unsigned SAMPLE_W   = 15;

   // FIFO entry: two sign-extended samples plus burst flags
   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        first;
      logic        last;
   } sample_t;

   typedef enum logic {
      StIdle  = 1'b0,
      StBurst = 1'b1
   } state_t;

   function automatic logic [15:0] sext15(input logic [SAMPLE_W-1:0] v);
      return {v[SAMPLE_W-1], v};
   endfunction

   // Increment that sticks at all-ones
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/adc_stream_rx_sync_fifo_fwft.sv
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO with registered storage. The
// head entry is visible on o_rdata whenever o_empty is low. Pointers carry
// one extra wrap bit so full and empty are distinguished without a counter.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_push, i_wdata    write request and data (ignored when full)
//   i_pop              consume the head entry (ignored when empty)
//   o_rdata            head entry
//   o_full, o_empty    occupancy flags
module sync_fifo_fwft #(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;
   assign o_rdata   = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage needs no reset; empty flag masks stale contents
   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/adc_stream_rx.sv
// adc_stream_rx
// AXI-Stream sink for tagged ADC sample words. Checks burst framing, unpacks
// each word into two signed 16-bit samples, buffers them in a FWFT FIFO and
// keeps burst/error statistics.
// Ports:
//   aclk, aresetn                     clock, asynchronous active-low reset
//   s_axis_tvalid/tready/tdata/tlast  input stream; tready = FIFO not full
//   limiter                           expected burst length is 2^limiter words
//   clear_stats                       synchronous clear of statistics
//   m_sample_*                        FIFO head with valid/ready handshake
//   in_burst                          receiver is inside a burst
//   words_count .. err_length         statistics counters
module adc_stream_rx
   import adc_stream_rx_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tlast,
   input  logic [7:0]  limiter,
   input  logic        clear_stats,
   output logic        m_sample_valid,
   input  logic        m_sample_ready,
   output logic [15:0] m_sample_a,
   output logic [15:0] m_sample_b,
   output logic        m_sample_first,
   output logic        m_sample_last,
   output logic        in_burst,
   output logic [63:0] words_count,
   output logic [31:0] bursts_count,
   output logic [15:0] err_marker,
   output logic [15:0] err_last,
   output logic [15:0] err_length
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [63:0] r_burst_cnt;
   logic [7:0]  r_lim;
   logic        r_seen_good;

   logic        w_full;
   logic        w_empty;
   logic        w_hs;
   logic        w_good;
   logic        w_start;
   logic [63:0] w_cnt_cur;
   logic [63:0] w_cnt_new;
   logic [7:0]  w_lim;
   logic        w_seen;
   logic [63:0] w_len_exp;
   logic        w_len_err;
   logic        w_last_err;
   logic        w_marker_err;
   logic        w_push;
   sample_t     w_wdata;
   sample_t     w_rdata;

   logic [63:0] r_words;
   logic [31:0] r_bursts;
   logic [15:0] r_err_marker;
   logic [15:0] r_err_last;
   logic [15:0] r_err_length;

   assign s_axis_tready = ~w_full;
   assign w_hs          = s_axis_tvalid & ~w_full;
   assign w_good        = s_axis_tdata[MARKER_BIT];
   assign w_start       = (r_state == StIdle);

   // Values as seen by the current word; a word arriving in IDLE starts fresh
   assign w_cnt_cur = w_start ? 64'd0 : r_burst_cnt;
   assign w_cnt_new = w_cnt_cur + 64'd1;
   assign w_lim     = w_start ? limiter : r_lim;
   assign w_seen    = w_start ? 1'b0 : r_seen_good;

   // Length check only meaningful while 2^limiter fits in the 64-bit counter
   assign w_len_exp    = 64'd1 << w_lim[5:0];
   assign w_len_err    = w_hs & s_axis_tlast & (w_lim <= 8'd63) & (w_cnt_new != w_len_exp);
   assign w_last_err   = w_hs & (s_axis_tdata[LAST_BIT] != s_axis_tlast);
   assign w_marker_err = w_hs & ~w_good;
   assign w_push       = w_hs & w_good;

   assign w_wdata = {sext15(s_axis_tdata[A_MSB:A_LSB]),
                     sext15(s_axis_tdata[B_MSB:0]),
                     ~w_seen,
                     s_axis_tlast};

   sync_fifo_fwft #(
      .WIDTH ($bits(sample_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (aclk),
      .i_rst_n (aresetn),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (m_sample_ready),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Head fields forced to zero while empty so unwritten storage never leaks
   assign m_sample_valid = ~w_empty;
   assign m_sample_a     = w_empty ? 16'd0 : w_rdata.a;
   assign m_sample_b     = w_empty ? 16'd0 : w_rdata.b;
   assign m_sample_first = ~w_empty & w_rdata.first;
   assign m_sample_last  = ~w_empty & w_rdata.last;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= StIdle;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (w_hs && !s_axis_tlast) w_state_nxt = StBurst;
         StBurst: if (w_hs && s_axis_tlast)  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   assign in_burst = (r_state == StBurst);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_burst_cnt <= 64'd0;
         r_lim       <= 8'd0;
         r_seen_good <= 1'b0;
      end else if (w_hs) begin
         r_burst_cnt <= s_axis_tlast ? 64'd0 : w_cnt_new;
         r_lim       <= w_lim;
         r_seen_good <= s_axis_tlast ? 1'b0 : (w_seen | w_good);
      end
   end

   // Clear takes priority over any increment on the same edge
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_words      <= 64'd0;
         r_bursts     <= 32'd0;
         r_err_marker <= 16'd0;
         r_err_last   <= 16'd0;
         r_err_length <= 16'd0;
      end else if (clear_stats) begin
         r_words      <= 64'd0;
         r_bursts     <= 32'd0;
         r_err_marker <= 16'd0;
         r_err_last   <= 16'd0;
         r_err_length <= 16'd0;
      end else begin
         if (w_push)                 r_words      <= r_words + 64'd1;
         if (w_hs && s_axis_tlast)   r_bursts     <= r_bursts + 32'd1;
         if (w_marker_err)           r_err_marker <= sat_inc16(r_err_marker);
         if (w_last_err)             r_err_last   <= sat_inc16(r_err_last);
         if (w_len_err)              r_err_length <= sat_inc16(r_err_length);
      end
   end

   assign words_count  = r_words;
   assign bursts_count = r_bursts;
   assign err_marker   = r_err_marker;
   assign err_last     = r_err_last;
   assign err_length   = r_err_length;

endmodule
